// File: rtl/secret_word_loader.sv
// Assembles a little-endian 32-bit key word from a byte stream, delivers it with a one-cycle
// strobe, then zeroizes all staging. Define SECRET_LOADER_CHECK_EN to require a trailing check byte.
module secret_word_loader #(
    parameter int unsigned SCRUB_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        abort,
    output logic [31:0] secret_word,
    output logic        load_secret,
    output logic        load_error,
    output logic        busy
);

    // state     | meaning
    // S_IDLE    | waiting for the first byte of a frame
    // S_COLLECT | gathering key bytes 1..3
    // S_CHECK   | waiting for the check byte (check build only)
    // S_DELIVER | one-cycle strobe with the assembled word
    // S_SCRUB   | staging zeroized, hold off new frames
`ifdef SECRET_LOADER_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CHECK, S_DELIVER, S_SCRUB} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DELIVER, S_SCRUB} state_t;
`endif

    localparam logic [3:0] SCRUB_LOAD = 4'(SCRUB_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam bit         TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t      state, state_next;
    logic [31:0] staging, staging_next;
    logic [1:0]  byte_cnt;
    logic [7:0]  gap_cnt;
    logic [3:0]  scrub_cnt;
    logic        in_frame;
    logic        accept;
    logic        timeout;
    logic        error_next;

`ifdef SECRET_LOADER_CHECK_EN
    logic [7:0] check_byte;
    assign check_byte = staging[7:0] ^ staging[15:8] ^ staging[23:16] ^ staging[31:24] ^ 8'hA5;
    assign in_frame   = (state == S_COLLECT) || (state == S_CHECK);
`else
    assign in_frame   = (state == S_COLLECT);
`endif

    assign in_ready = ((state == S_IDLE) || in_frame) && !abort && !rst;
    assign accept   = in_valid && in_ready;
    // fires on the idle edge that would take gap_cnt to TIMEOUT_CYCLES
    assign timeout  = TIMEOUT_EN && in_frame && !accept && (gap_cnt == GAP_LAST);

    always_comb begin
        state_next   = state;
        error_next   = 1'b0;
        staging_next = staging;
        if (accept && ((state == S_IDLE) || (state == S_COLLECT)))
            staging_next[{byte_cnt, 3'b000} +: 8] = in_byte;

        case (state)
            S_IDLE: begin
                if (abort)
                    state_next = S_SCRUB;
                else if (accept)
                    state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (abort) begin
                    state_next = S_SCRUB;
                end else if (timeout) begin
                    state_next = S_SCRUB;
                    error_next = 1'b1;
                end else if (accept && (byte_cnt == 2'd3)) begin
`ifdef SECRET_LOADER_CHECK_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DELIVER;
`endif
                end
            end
`ifdef SECRET_LOADER_CHECK_EN
            S_CHECK: begin
                if (abort) begin
                    state_next = S_SCRUB;
                end else if (timeout) begin
                    state_next = S_SCRUB;
                    error_next = 1'b1;
                end else if (accept) begin
                    if (in_byte == check_byte) begin
                        state_next = S_DELIVER;
                    end else begin
                        state_next = S_SCRUB;
                        error_next = 1'b1;
                    end
                end
            end
`endif
            S_DELIVER: state_next = S_SCRUB;
            S_SCRUB: begin
                if (!abort && (scrub_cnt == 4'd0))
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            staging     <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            scrub_cnt   <= '0;
            secret_word <= '0;
            load_secret <= 1'b0;
            load_error  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            load_error  <= error_next;
            load_secret <= (state_next == S_DELIVER);
            busy        <= (state_next != S_IDLE);
            if (state_next == S_SCRUB) begin
                staging     <= '0;
                secret_word <= '0;
                byte_cnt    <= '0;
                gap_cnt     <= '0;
                // entry or abort restarts the scrub window
                if ((state != S_SCRUB) || abort)
                    scrub_cnt <= SCRUB_LOAD;
                else
                    scrub_cnt <= scrub_cnt - 4'd1;
            end else begin
                staging <= staging_next;
                if (accept) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    gap_cnt  <= '0;
                end else if (in_frame && TIMEOUT_EN) begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                if (state_next == S_DELIVER)
                    secret_word <= staging_next;
            end
        end
    end

endmodule

// File: tb/tb_secret_word_loader.sv
// Scoreboard bench for secret_word_loader: frames are modelled as byte lists with idle gaps,
// expected deliveries/errors are queued, and a negedge monitor pops them on each strobe.
module tb_secret_word_loader;

    localparam int SCRUB = 2;
    localparam int TMO   = 16;
`ifdef SECRET_LOADER_CHECK_EN
    localparam int FLEN  = 5;
`else
    localparam int FLEN  = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        abort;
    logic [31:0] secret_word;
    logic        load_secret;
    logic        load_error;
    logic        busy;

    secret_word_loader #(.SCRUB_CYCLES(SCRUB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .abort(abort), .secret_word(secret_word), .load_secret(load_secret),
        .load_error(load_error), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [31:0] word;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_en = 1'b0;
    logic [7:0] fb[5];
    int         fg[5];
    int         fabort;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] xor_chk(input logic [7:0] a, b, c, d);
        return a ^ b ^ c ^ d ^ 8'hA5;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (load_secret || load_error) begin
                chk("strobe_exclusive", 32'(load_secret && load_error), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got load_secret=%0b load_error=%0b expected none at %0t",
                             load_secret, load_error, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_error", 32'(load_error), 32'(e.is_err));
                    if (!e.is_err)
                        chk("secret_word", secret_word, e.word);
                end
            end else begin
                chk("word_zero_outside_strobe", secret_word, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            tick();
            @(negedge clk);
            waited++;
        end
        chk("byte_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    task automatic pulse_abort();
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        abort    = 1'b1;
        @(negedge clk);
        chk("ready_low_on_abort", 32'(in_ready), 32'd0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("return_to_idle", 32'(busy), 32'd0);
        chk("staging_zeroized", dut.staging, 32'd0);
        chk("ready_in_idle", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic count_not_ready(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        tick();
    endtask

    task automatic set_frame(input logic [7:0] b0, b1, b2, b3);
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
        fb[4] = xor_chk(b0, b1, b2, b3);
        for (int i = 0; i < 5; i++) fg[i] = 0;
        fabort = -1;
    endtask

    // Reference: a gap of TMO or more idle cycles ends the frame with an error, an abort
    // placed before that point silently drops the frame, otherwise the word (or check error) results.
    task automatic run_frame(input bit settle);
        int   n_send;
        bit   tmo;
        bit   abrt;
        bit   bad;
        exp_t e;
        n_send = FLEN;
        tmo    = 1'b0;
        abrt   = 1'b0;
        bad    = 1'b0;
        for (int i = 1; i < FLEN; i++)
            if (!tmo && fg[i] >= TMO) begin
                n_send = i;
                tmo    = 1'b1;
            end
        if (fabort >= 0 && fabort <= n_send) begin
            n_send = fabort;
            tmo    = 1'b0;
            abrt   = 1'b1;
        end
`ifdef SECRET_LOADER_CHECK_EN
        bad = (fb[4] != xor_chk(fb[0], fb[1], fb[2], fb[3]));
`endif
        if (!abrt) begin
            e.is_err = tmo || bad;
            e.word   = {fb[3], fb[2], fb[1], fb[0]};
            exp_q.push_back(e);
        end
        for (int i = 0; i < n_send; i++) begin
            if (i > 0) idle(fg[i]);
            send_byte(fb[i]);
        end
        if (abrt)
            pulse_abort();
        else if (tmo)
            idle(fg[n_send]);
        if (settle) wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d expected events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; abort = 1'b0;
        @(negedge clk);
        chk("ready_low_in_reset", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("reset_word", secret_word, 32'd0);
        chk("reset_load_secret", 32'(load_secret), 32'd0);
        chk("reset_load_error", 32'(load_error), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        mon_en = 1'b1;
        tick();

        // back-to-back frame, then the DELIVER + scrub window with in_ready low
        set_frame(8'h11, 8'h22, 8'h33, 8'h44);
        run_frame(1'b0);
        count_not_ready(c);
        chk("not_ready_window", 32'(c), 32'(1 + SCRUB));

`ifdef SECRET_LOADER_CHECK_EN
        set_frame(8'h11, 8'h22, 8'h33, 8'h44);
        fb[4] = 8'hE0;
        run_frame(1'b1);
`endif

        // timeout after two bytes, then a clean frame with no residue
        set_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        fg[2] = TMO;
        run_frame(1'b1);
        set_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        run_frame(1'b1);

        // one idle cycle short of the timeout
        set_frame(8'h01, 8'h80, 8'hFF, 8'h7E);
        fg[3] = TMO - 1;
        run_frame(1'b1);

        // abort after three bytes with in_valid held high
        set_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        fabort = 3;
        run_frame(1'b1);

        // abort during scrub restarts the scrub count
        set_frame(8'h12, 8'h34, 8'h56, 8'h78);
        run_frame(1'b0);
        tick();
        pulse_abort();
        count_not_ready(c);
        chk("scrub_restart_window", 32'(c), 32'(SCRUB));

        // reset mid-frame discards the partial word
        set_frame(8'hC0, 8'hFF, 8'hEE, 8'h01);
        for (int i = 0; i < FLEN - 1; i++) send_byte(fb[i]);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_low_in_reset_mid", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_word", secret_word, 32'd0);
        chk("midrst_load_secret", 32'(load_secret), 32'd0);
        chk("midrst_load_error", 32'(load_error), 32'd0);
        chk("midrst_staging", dut.staging, 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        tick();
        set_frame(8'h0F, 8'h1E, 8'h2D, 8'h3C);
        run_frame(1'b1);

        // in_valid toggling every other cycle
        set_frame(8'h9A, 8'h8B, 8'h7C, 8'h6D);
        for (int i = 1; i < 5; i++) fg[i] = 1;
        run_frame(1'b1);

        for (int f = 0; f < 40; f++) begin
            set_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
            for (int i = 1; i < 5; i++) begin
                r = int'($urandom_range(0, 19));
                if (r < 16)       fg[i] = int'($urandom_range(0, 2));
                else if (r < 18)  fg[i] = TMO - 1;
                else if (r == 18) fg[i] = TMO;
                else              fg[i] = TMO + int'($urandom_range(1, 4));
            end
            if ($urandom_range(0, 7) == 0) fabort = int'($urandom_range(0, FLEN - 1));
            run_frame(1'b1);
            idle(int'($urandom_range(0, 3)));
        end

        idle(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
